mem_seq_arbiter: RTL

Sequences the single-cycle processor core onto one shared, variable-latency, single-port memory. Each instruction runs the same order: fetch the instruction, optionally do one data access, then commit. The block latches `cpu_instr` and `cpu_data_out` so the core's combinational datapath sees stable values. It pulses `cpu_pc_enable` for exactly one cycle per retired instruction. It sits between the core's `inst_addr`/`data_addr`/`mem_read_ctrlsig`/`mem_write_ctrlsig` outputs and the memory.

---
 rtl/mem_seq_pkg.sv | 15 +
 rtl/mem_seq_watchdog.sv | 27 ++
 rtl/mem_seq_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the memory sequencer (state encoding, default watchdog limit).
package mem_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        DATA   = 3'd3,
        COMMIT = 3'd4,
        HALT   = 3'd5
    } mem_seq_state_t;

    localparam int unsigned MEM_SEQ_TIMEOUT_DEFAULT = 32'd255;

endpackage

// File: rtl/mem_seq_watchdog.sv
// Wait-cycle counter for the memory sequencer; flags expiry on the wait cycle that reaches LIMIT.
module mem_seq_watchdog
    import mem_seq_pkg::*;
#(
    parameter int unsigned LIMIT = MEM_SEQ_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic waiting,
    output logic expired
);

    logic [31:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= 32'd0;
        end else if (waiting) begin
            count_reg <= count_reg + 32'd1;
        end
    end

    // This wait cycle is the LIMIT-th one, so the caller leaves for HALT at this edge.
    assign expired = waiting && (count_reg >= (LIMIT - 32'd1));

endmodule

// File: rtl/mem_seq_arbiter.sv
// Fetch / optional data access / commit sequencer between a single-cycle core and one shared memory.
// Optional watchdog timeout is enabled by defining MEM_SEQ_TIMEOUT_EN.
module mem_seq_arbiter
    import mem_seq_pkg::*;
#(
    parameter int          ADDR_W         = 32,
    parameter int          DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = MEM_SEQ_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [ADDR_W-1:0] cpu_inst_addr,
    input  logic [ADDR_W-1:0] cpu_data_addr,
    input  logic [DATA_W-1:0] cpu_data_in,
    input  logic              cpu_mem_read,
    input  logic              cpu_mem_write,
    output logic [DATA_W-1:0] cpu_instr,
    output logic [DATA_W-1:0] cpu_data_out,
    output logic              cpu_pc_enable,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err,
    output logic [31:0]       instret
);

    mem_seq_state_t    state_reg;
    logic              mem_req_reg;
    logic              mem_we_reg;
    logic              pc_enable_reg;
    logic              err_reg;
    logic [DATA_W-1:0] instr_reg;
    logic [DATA_W-1:0] data_out_reg;
    logic [31:0]       instret_reg;
    logic              wd_expired;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("mem_seq_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef MEM_SEQ_TIMEOUT_EN
    // Request is low in every state preceding FETCH/DATA, so holding clear while idle resets on entry.
    mem_seq_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (!mem_req_reg),
        .waiting (mem_req_reg && !mem_ready),
        .expired (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            pc_enable_reg <= 1'b0;
            err_reg       <= 1'b0;
            instr_reg     <= '0;
            data_out_reg  <= '0;
            instret_reg   <= 32'd0;
        end else begin
            pc_enable_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (run) begin
                        state_reg   <= FETCH;
                        mem_req_reg <= 1'b1;
                        mem_we_reg  <= 1'b0;
                    end
                end
                FETCH: begin
                    if (mem_ready) begin
                        instr_reg   <= mem_rdata;
                        state_reg   <= DECODE;
                        mem_req_reg <= 1'b0;
                    end else if (wd_expired) begin
                        state_reg   <= HALT;
                        mem_req_reg <= 1'b0;
                        err_reg     <= 1'b1;
                    end
                end
                DECODE: begin
                    // A store wins over a simultaneous load request.
                    if (cpu_mem_write || cpu_mem_read) begin
                        state_reg   <= DATA;
                        mem_req_reg <= 1'b1;
                        mem_we_reg  <= cpu_mem_write;
                    end else begin
                        state_reg     <= COMMIT;
                        pc_enable_reg <= 1'b1;
                    end
                end
                DATA: begin
                    if (mem_ready) begin
                        if (!mem_we_reg) begin
                            data_out_reg <= mem_rdata;
                        end
                        state_reg     <= COMMIT;
                        mem_req_reg   <= 1'b0;
                        mem_we_reg    <= 1'b0;
                        pc_enable_reg <= 1'b1;
                    end else if (wd_expired) begin
                        state_reg   <= HALT;
                        mem_req_reg <= 1'b0;
                        mem_we_reg  <= 1'b0;
                        err_reg     <= 1'b1;
                    end
                end
                COMMIT: begin
                    instret_reg <= instret_reg + 32'd1;
                    if (run) begin
                        state_reg   <= FETCH;
                        mem_req_reg <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                HALT: begin
                    state_reg <= HALT;
                end
                default: begin
                    state_reg   <= IDLE;
                    mem_req_reg <= 1'b0;
                    mem_we_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Address/data come straight from the core, whose outputs are stable while the request is open.
    assign mem_req       = mem_req_reg;
    assign mem_we        = mem_we_reg;
    assign mem_addr      = !mem_req_reg        ? '0 :
                           (state_reg == DATA) ? cpu_data_addr : cpu_inst_addr;
    assign mem_wdata     = (mem_req_reg && mem_we_reg) ? cpu_data_in : '0;
    assign cpu_instr     = instr_reg;
    assign cpu_data_out  = data_out_reg;
    assign cpu_pc_enable = pc_enable_reg;
    assign busy          = (state_reg != IDLE);
    assign err           = err_reg;
    assign instret       = instret_reg;

endmodule
